// File: rtl/phy_pkg.sv
// Shared definitions for the two-lane serial PHY (phy_tx / phy_rx).
// Holds the link defaults and the receive FSM state encoding.
package phy_pkg;

    localparam logic [7:0]  COMMA_DEFAULT    = 8'hBC;
    localparam int unsigned LOCK_CNT_DEFAULT = 4;
    localparam int unsigned ERR_CNT_DEFAULT  = 4;

    typedef enum logic [1:0] {
        StSearch = 2'd0,
        StLock   = 2'd1,
        StActive = 2'd2
    } phy_state_e;

endpackage

// File: rtl/phy_rx_lane.sv
// One receive lane: 8-bit MSB-first shift register and the byte window it presents.
// byte_o includes the bit sampled at the current edge, so it is the complete byte at a boundary.
module phy_rx_lane
    import phy_pkg::*;
#(
    parameter logic [7:0] Comma = COMMA_DEFAULT
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       bit_i,
    output logic [7:0] byte_o,
    output logic       comma_o
);

    logic [7:0] shift_q;
    logic [7:0] shift_d;

    always_comb begin
        shift_d = {shift_q[6:0], bit_i};
        byte_o  = shift_d;
        comma_o = (shift_d == Comma);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            shift_q <= 8'h00;
        end else begin
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/phy_rx.sv
// Two-lane serial receiver: comma alignment/lock FSM and 32-bit word reassembly.
// Lane 0 carries Data[31:16], lane 1 carries Data[15:0], high byte pair first.
module phy_rx
    import phy_pkg::*;
#(
    parameter logic [7:0]  COMMA    = COMMA_DEFAULT,
    parameter int unsigned LOCK_CNT = LOCK_CNT_DEFAULT,
    parameter int unsigned ERR_CNT  = ERR_CNT_DEFAULT
) (
    input  logic        clk_32f,
    input  logic        reset,
    input  logic        Data_in_1bit_0,
    input  logic        Data_in_1bit_1,
    output logic [31:0] Data_out,
    output logic        valid_out,
    output logic        active_out,
    output logic        err_out
);

    logic [7:0] byte0, byte1;
    logic       comma0, comma1;

    phy_rx_lane #(.Comma(COMMA)) u_lane0 (
        .clk_i   (clk_32f),
        .reset_i (reset),
        .bit_i   (Data_in_1bit_0),
        .byte_o  (byte0),
        .comma_o (comma0)
    );

    phy_rx_lane #(.Comma(COMMA)) u_lane1 (
        .clk_i   (clk_32f),
        .reset_i (reset),
        .bit_i   (Data_in_1bit_1),
        .byte_o  (byte1),
        .comma_o (comma1)
    );

    phy_state_e  state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  comma_cnt_q, comma_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        phase_q, phase_d;
    logic [31:0] word_q, word_d;
    logic        pend_q, pend_d;
    logic [31:0] data_out_q;
    logic        valid_q, active_q, err_q, err_d;
    logic        boundary, both_comma, none_comma;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q + 3'd1;
        comma_cnt_d = comma_cnt_q;
        err_cnt_d   = err_cnt_q;
        phase_d     = phase_q;
        word_d      = word_q;
        pend_d      = 1'b0;
        err_d       = 1'b0;
        boundary    = (bit_cnt_q == 3'd7);
        both_comma  = comma0 & comma1;
        none_comma  = ~comma0 & ~comma1;

        unique case (state_q)
            StSearch: begin
                // Bit-level hunt: a comma on both lanes defines the byte boundary.
                if (both_comma) begin
                    bit_cnt_d   = 3'd0;
                    comma_cnt_d = 8'd1;
                    state_d     = StLock;
                end
            end
            StLock: begin
                if (boundary) begin
                    if (both_comma) begin
                        comma_cnt_d = comma_cnt_q + 8'd1;
                        if (comma_cnt_d == 8'(LOCK_CNT)) begin
                            state_d     = StActive;
                            comma_cnt_d = 8'd0;
                            err_cnt_d   = 8'd0;
                            phase_d     = 1'b0;
                        end
                    end else begin
                        state_d     = StSearch;
                        comma_cnt_d = 8'd0;
                    end
                end
            end
            StActive: begin
                if (boundary) begin
                    if (both_comma) begin
                        phase_d   = 1'b0;
                        err_cnt_d = 8'd0;
                    end else if (none_comma) begin
                        err_cnt_d = 8'd0;
                        if (!phase_q) begin
                            word_d[31:24] = byte0;
                            word_d[15:8]  = byte1;
                            phase_d       = 1'b1;
                        end else begin
                            word_d[23:16] = byte0;
                            word_d[7:0]   = byte1;
                            phase_d       = 1'b0;
                            pend_d        = 1'b1;
                        end
                    end else begin
                        // Lane mismatch: drop any half-assembled word.
                        err_d     = 1'b1;
                        phase_d   = 1'b0;
                        err_cnt_d = err_cnt_q + 8'd1;
                        if (err_cnt_d == 8'(ERR_CNT)) begin
                            state_d   = StSearch;
                            err_cnt_d = 8'd0;
                        end
                    end
                end
            end
            default: state_d = StSearch;
        endcase
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_q     <= StSearch;
            bit_cnt_q   <= 3'd0;
            comma_cnt_q <= 8'd0;
            err_cnt_q   <= 8'd0;
            phase_q     <= 1'b0;
            word_q      <= 32'h0;
            pend_q      <= 1'b0;
            data_out_q  <= 32'h0;
            valid_q     <= 1'b0;
            active_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            comma_cnt_q <= comma_cnt_d;
            err_cnt_q   <= err_cnt_d;
            phase_q     <= phase_d;
            word_q      <= word_d;
            pend_q      <= pend_d;
            if (pend_q) begin
                data_out_q <= word_q;
            end
            valid_q     <= pend_q;
            active_q    <= (state_q == StActive);
            err_q       <= err_d;
        end
    end

    assign Data_out   = data_out_q;
    assign valid_out  = valid_q;
    assign active_out = active_q;
    assign err_out    = err_q;

endmodule

// File: tb/tb_phy_rx.sv
// Directed bench for phy_rx: lock, alignment, word assembly, idle interleave, mismatch, reset.
module tb_phy_rx;

    localparam logic [7:0] C = 8'hBC;

    logic        clk_32f = 1'b0;
    logic        reset = 1'b1;
    logic        d0 = 1'b0;
    logic        d1 = 1'b0;
    logic [31:0] Data_out;
    logic        valid_out, active_out, err_out;

    phy_rx dut (
        .clk_32f        (clk_32f),
        .reset          (reset),
        .Data_in_1bit_0 (d0),
        .Data_in_1bit_1 (d1),
        .Data_out       (Data_out),
        .valid_out      (valid_out),
        .active_out     (active_out),
        .err_out        (err_out)
    );

    always #5 clk_32f = ~clk_32f;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int vcount = 0;
    int vcyc = 0;
    logic [31:0] vdata = 32'h0;
    int ecount = 0;
    int act_rise = 0;
    logic act_prev = 1'b0;

    always @(posedge clk_32f) cyc <= cyc + 1;

    // Event monitor sampled mid-cycle.
    always @(negedge clk_32f) begin
        if (valid_out === 1'b1) begin
            vcount = vcount + 1;
            vcyc = cyc;
            vdata = Data_out;
        end
        if (err_out === 1'b1) ecount = ecount + 1;
        if (active_out === 1'b1 && act_prev !== 1'b1) act_rise = cyc;
        act_prev = active_out;
    end

    task send_pair(input logic [7:0] b0, input logic [7:0] b1);
        for (int i = 7; i >= 0; i--) begin
            d0 = b0[i];
            d1 = b1[i];
            @(posedge clk_32f);
            #1;
        end
    endtask

    task do_reset();
        d0 = 1'b0;
        d1 = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk_32f);
        #1;
        reset = 1'b0;
    endtask

    task lock_link(output int lock_e);
        repeat (4) send_pair(C, C);
        lock_e = cyc;
    endtask

    task test_reset();
        do_reset();
        tests++; if (Data_out !== 32'h0) begin fails++; $display("FAIL reset_data: got %h want %h", Data_out, 32'h0); end
        tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", valid_out); end
        tests++; if (active_out !== 1'b0) begin fails++; $display("FAIL reset_active: got %b want 0", active_out); end
        tests++; if (err_out !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err_out); end
        send_pair(8'h00, 8'h00);
        send_pair(8'h00, 8'h00);
        tests++; if (active_out !== 1'b0) begin fails++; $display("FAIL idle_zero_active: got %b want 0", active_out); end
    endtask

    task test_lock();
        int le;
        do_reset();
        act_rise = 0;
        lock_link(le);
        tests++; if (active_out !== 1'b0) begin fails++; $display("FAIL lock_active_at_32nd: got %b want 0", active_out); end
        send_pair(C, C);
        tests++; if (act_rise !== le + 1) begin fails++; $display("FAIL lock_rise_cycle: got %0d want %0d", act_rise, le + 1); end
    endtask

    task test_lock_fail();
        int le;
        do_reset();
        act_rise = 0;
        repeat (3) send_pair(C, C);
        send_pair(8'h00, 8'h00);
        tests++; if (active_out !== 1'b0) begin fails++; $display("FAIL lockfail_active: got %b want 0", active_out); end
        repeat (3) send_pair(C, C);
        tests++; if (act_rise !== 0) begin fails++; $display("FAIL lockfail_count_cleared: got rise %0d want 0", act_rise); end
        send_pair(C, C);
        le = cyc;
        send_pair(C, C);
        tests++; if (act_rise !== le + 1) begin fails++; $display("FAIL relock_rise_cycle: got %0d want %0d", act_rise, le + 1); end
    endtask

    task test_data();
        int le, v0, e16;
        do_reset();
        lock_link(le);
        send_pair(C, C);
        v0 = vcount;
        send_pair(8'hDE, 8'hBE);
        send_pair(8'hAD, 8'hEF);
        e16 = cyc;
        send_pair(C, C);
        tests++; if (vcount - v0 !== 1) begin fails++; $display("FAIL data_pulses: got %0d want 1", vcount - v0); end
        tests++; if (vcyc !== e16 + 1) begin fails++; $display("FAIL data_latency: got %0d want %0d", vcyc, e16 + 1); end
        tests++; if (vdata !== 32'hDEADBEEF) begin fails++; $display("FAIL data_value: got %h want %h", vdata, 32'hDEADBEEF); end
        tests++; if (Data_out !== 32'hDEADBEEF) begin fails++; $display("FAIL data_hold: got %h want %h", Data_out, 32'hDEADBEEF); end
    endtask

    task test_misalign();
        int le, v0, e16;
        logic [2:0] junk;
        do_reset();
        act_rise = 0;
        junk = 3'b101;
        for (int i = 2; i >= 0; i--) begin
            d0 = junk[i];
            d1 = junk[i];
            @(posedge clk_32f);
            #1;
        end
        lock_link(le);
        send_pair(C, C);
        tests++; if (act_rise !== le + 1) begin fails++; $display("FAIL misalign_rise: got %0d want %0d", act_rise, le + 1); end
        v0 = vcount;
        send_pair(8'hDE, 8'hBE);
        send_pair(8'hAD, 8'hEF);
        e16 = cyc;
        send_pair(C, C);
        tests++; if (vcount - v0 !== 1) begin fails++; $display("FAIL misalign_pulses: got %0d want 1", vcount - v0); end
        tests++; if (vcyc !== e16 + 1) begin fails++; $display("FAIL misalign_latency: got %0d want %0d", vcyc, e16 + 1); end
        tests++; if (vdata !== 32'hDEADBEEF) begin fails++; $display("FAIL misalign_value: got %h want %h", vdata, 32'hDEADBEEF); end
    endtask

    task test_idle_interleave();
        int le, v0, e1, e2;
        do_reset();
        lock_link(le);
        send_pair(C, C);
        v0 = vcount;
        send_pair(8'h01, 8'h03);
        send_pair(8'h02, 8'h04);
        e1 = cyc;
        send_pair(C, C);
        tests++; if (vcyc !== e1 + 1) begin fails++; $display("FAIL ilv_word1_latency: got %0d want %0d", vcyc, e1 + 1); end
        tests++; if (vdata !== 32'h01020304) begin fails++; $display("FAIL ilv_word1_value: got %h want %h", vdata, 32'h01020304); end
        // Orphan high half, then an idle slot that must restart the word.
        send_pair(8'h77, 8'h88);
        send_pair(C, C);
        send_pair(8'h0A, 8'h0C);
        send_pair(8'h0B, 8'h0D);
        e2 = cyc;
        send_pair(C, C);
        tests++; if (vcount - v0 !== 2) begin fails++; $display("FAIL ilv_pulses: got %0d want 2", vcount - v0); end
        tests++; if (vcyc !== e2 + 1) begin fails++; $display("FAIL ilv_word2_latency: got %0d want %0d", vcyc, e2 + 1); end
        tests++; if (vdata !== 32'h0A0B0C0D) begin fails++; $display("FAIL ilv_word2_value: got %h want %h", vdata, 32'h0A0B0C0D); end
    endtask

    // Continues from the locked link left by test_idle_interleave.
    task test_mismatch();
        int e0, v0;
        e0 = ecount;
        v0 = vcount;
        repeat (3) send_pair(C, 8'h55);
        tests++; if (active_out !== 1'b1) begin fails++; $display("FAIL mm_active_after3: got %b want 1", active_out); end
        send_pair(C, 8'h55);
        send_pair(8'h00, 8'h00);
        tests++; if (ecount - e0 !== 4) begin fails++; $display("FAIL mm_err_pulses: got %0d want 4", ecount - e0); end
        tests++; if (active_out !== 1'b0) begin fails++; $display("FAIL mm_active_after4: got %b want 0", active_out); end
        tests++; if (Data_out !== 32'h0A0B0C0D) begin fails++; $display("FAIL mm_data_hold: got %h want %h", Data_out, 32'h0A0B0C0D); end
        tests++; if (vcount !== v0) begin fails++; $display("FAIL mm_no_valid: got %0d want %0d", vcount, v0); end
    endtask

    // Continues from the unlocked link left by test_mismatch.
    task test_reset_midword();
        int le, v0;
        lock_link(le);
        send_pair(C, C);
        v0 = vcount;
        act_rise = 0;
        send_pair(8'hDE, 8'hBE);
        do_reset();
        tests++; if (Data_out !== 32'h0) begin fails++; $display("FAIL mid_reset_data: got %h want %h", Data_out, 32'h0); end
        tests++; if (active_out !== 1'b0) begin fails++; $display("FAIL mid_reset_active: got %b want 0", active_out); end
        tests++; if (valid_out !== 1'b0 || err_out !== 1'b0) begin fails++; $display("FAIL mid_reset_pulses: got valid %b err %b want 0 0", valid_out, err_out); end
        send_pair(8'hAD, 8'hEF);
        repeat (3) send_pair(C, C);
        tests++; if (active_out !== 1'b0) begin fails++; $display("FAIL mid_relock_early: got %b want 0", active_out); end
        tests++; if (vcount !== v0) begin fails++; $display("FAIL mid_stale_valid: got %0d want %0d", vcount, v0); end
        send_pair(C, C);
        send_pair(C, C);
        tests++; if (active_out !== 1'b1) begin fails++; $display("FAIL mid_relock: got %b want 1", active_out); end
        send_pair(8'h12, 8'h56);
        send_pair(8'h34, 8'h78);
        send_pair(C, C);
        tests++; if (vcount - v0 !== 1) begin fails++; $display("FAIL mid_pulses: got %0d want 1", vcount - v0); end
        tests++; if (vdata !== 32'h12345678) begin fails++; $display("FAIL mid_value: got %h want %h", vdata, 32'h12345678); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_lock_fail();
        test_data();
        test_misalign();
        test_idle_interleave();
        test_mismatch();
        test_reset_midword();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/phy_rx.md
PHY_RX -- requirements
Module: phy_rx

Interface
REQ-001 SHALL have parameter COMMA, default 8'hBC, meaning the idle/alignment byte sent by the transmitter when it has no valid data.
REQ-002 SHALL have parameter LOCK_CNT, default 4, meaning the number of consecutive aligned COMMA bytes on both lanes needed to go active.
REQ-003 SHALL have parameter ERR_CNT, default 4, meaning the number of consecutive lane-mismatch byte slots that drop active.
REQ-004 SHALL have port clk_32f, input, 1 bit: the single clock; each rising edge samples one bit per lane.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port Data_in_1bit_0, input, 1 bit: serial lane 0, MSB first, carries Data[31:16].
REQ-007 SHALL have port Data_in_1bit_1, input, 1 bit: serial lane 1, MSB first, carries Data[15:0].
REQ-008 SHALL have port Data_out, output, 32 bits: the reassembled word.
REQ-009 SHALL have port valid_out, output, 1 bit: one-cycle pulse marking a new Data_out.
REQ-010 SHALL have port active_out, output, 1 bit: high while the link is locked.
REQ-011 SHALL have port err_out, output, 1 bit: one-cycle pulse per lane-mismatch byte slot while active.

Function
REQ-012 SHALL shift each lane into an 8-bit shift register on every clk_32f edge, new bit entering at LSB.
REQ-013 SHALL implement FSM states SEARCH, LOCK and ACTIVE.
REQ-014 In SEARCH, SHALL compare {shift[6:0], incoming bit} of both lanes to COMMA every cycle; when both match, SHALL clear the bit counter (declaring a byte boundary), set the comma count to 1 and enter LOCK.
REQ-015 In LOCK, at each byte boundary (bit counter wraps 7->0), SHALL increment the comma count if both lanes' bytes equal COMMA, otherwise return to SEARCH with the count cleared.
REQ-016 In LOCK, SHALL enter ACTIVE when the comma count reaches LOCK_CNT, and SHALL assert active_out from the following cycle.
REQ-017 In ACTIVE, each byte slot SHALL be classified as:
  - idle: both lanes equal COMMA;
  - data: neither lane equals COMMA;
  - mismatch: exactly one lane equals COMMA.
REQ-018 On an idle slot, SHALL clear the half-word phase so the next data slot is the high byte.
REQ-019 On a data slot at phase 0, SHALL store lane0 byte into Data[31:24] and lane1 byte into Data[15:8], then set phase to 1.
REQ-020 On a data slot at phase 1, SHALL store lane0 byte into Data[23:16] and lane1 byte into Data[7:0], clear phase, and update Data_out and pulse valid_out on the next edge.
REQ-021 Latency: valid_out SHALL rise exactly one edge after the edge sampling the 16th bit of the word.
REQ-022 A word containing a COMMA byte is unrepresentable by protocol; such a byte SHALL be treated per REQ-017 and no valid_out SHALL be generated for its word.
REQ-023 On a mismatch slot, SHALL pulse err_out, clear phase, discard the partial word and increment the mismatch count; any non-mismatch slot SHALL clear the count.
REQ-024 When the mismatch count reaches ERR_CNT, SHALL deassert active_out and return to SEARCH.
REQ-025 Data_out SHALL hold its last value between valid_out pulses and across loss of lock.

Reset
REQ-026 While reset is high at an edge, SHALL force:
  - state = SEARCH;
  - Data_out = 32'h0;
  - valid_out = 0, active_out = 0, err_out = 0;
  - shift registers, counters and phase = 0.
REQ-027 Reset asserted mid-word or mid-lock SHALL discard all partial state, and relock SHALL require LOCK_CNT fresh commas.

Structure
REQ-028 COMMA default, LOCK_CNT, ERR_CNT and the FSM state encodings SHALL live in a shared phy package/include used by phy_tx and phy_rx.
REQ-029 Per-lane shift and byte capture SHALL be one sub-module, phy_rx_lane, instantiated twice; FSM and word assembly SHALL stay in phy_rx.

Verification
REQ-030 Lock: 4 COMMA bytes on both lanes after reset -> active_out=1 one cycle after the 32nd bit; 3 commas then 8'h00 -> stays 0 and returns to SEARCH.
REQ-031 Bit misalignment: 3 junk bits, then commas -> lock achieved at shifted boundary, and a following 0xDEADBEEF is received correctly.
REQ-032 Data: lane0 DE,AD and lane1 BE,EF after lock -> Data_out=32'hDEADBEEF with a single valid_out pulse one edge after the 16th bit.
REQ-033 Idle interleave: word 32'h01020304, COMMA slot, then word 32'h0A0B0C0D -> two valid_out pulses with correct values and phase reset between them.
REQ-034 Mismatch: lane0 COMMA and lane1 8'h55 for 4 slots -> four err_out pulses, active_out=0 after the 4th, and Data_out unchanged.
REQ-035 Reset mid-word after the first byte pair -> all outputs 0, and no valid_out until relock plus a full word.
